pipeline_sequencer: RTL

Sequences the four-stage pipeline (F, D, E, W) of the processor: drives the load and clear enables of the PC and the D/E/W instruction registers. It stalls D on register read-after-write hazards and flushes wrong-path instructions on a taken branch. It drains the pipeline and halts when a stop instruction retires. It also keeps the cycle and stall counters read by the performance-counter logic.

---
 rtl/processor_pkg.sv | 46 ++++
 rtl/hazard_unit.sv | 85 ++++++++
 rtl/pipeline_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the four-stage (F, D, E, W) processor pipeline.
// Holds the opcode encodings, the instruction register-field positions, the
// sequencer state type and a small register-reference record used by hazard
// detection.
package processor_pkg;

  // Instruction layout: [3:0] opcode, [5:4] R2, [7:6] R1.
  localparam int unsigned OP_LSB = 0;
  localparam int unsigned OP_MSB = 3;
  localparam int unsigned R2_LSB = 4;
  localparam int unsigned R2_MSB = 5;
  localparam int unsigned R1_LSB = 6;
  localparam int unsigned R1_MSB = 7;

  // Full 4-bit opcodes.
  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STOP  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_BZ    = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_NAND  = 4'h8;
  localparam logic [3:0] OP_BNZ   = 4'h9;
  localparam logic [3:0] OP_NOP   = 4'hA;
  localparam logic [3:0] OP_BPZ   = 4'hD;

  // shift and ori ignore opcode bit 3 (x011 / x111).
  localparam logic [2:0] OP3_SHIFT = 3'b011;
  localparam logic [2:0] OP3_ORI   = 3'b111;

  // ori implicitly reads and writes register 1.
  localparam logic [1:0] ORI_REG = 2'd1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;

  // A register operand: whether it is used and which register it names.
  typedef struct packed {
    logic       en;
    logic [1:0] idx;
  } reg_ref_t;

endpackage

// File: rtl/hazard_unit.sv
// Combinational read-after-write hazard detector.
// Decodes the read set of the D-stage instruction and the write sets of the
// E- and W-stage instructions; flags a hazard when D reads a register that
// either older instruction will write. The register file has no bypass, so a
// writer still in W counts as well.
//
// Ports:
//   i_ir_d   instruction in D (reader)
//   i_ir_e   instruction in E (writer candidate)
//   i_ir_w   instruction in W (writer candidate)
//   o_hazard D must stall this cycle
module hazard_unit
  import processor_pkg::*;
(
  input  logic [7:0] i_ir_d,
  input  logic [7:0] i_ir_e,
  input  logic [7:0] i_ir_w,
  output logic       o_hazard
);

  // Destination register of an instruction, if it writes one.
  function automatic reg_ref_t dec_write(input logic [7:0] ir);
    logic [3:0] op;
    reg_ref_t   wr;
    op = ir[OP_MSB:OP_LSB];
    wr = '0;
    if (op == OP_LOAD || op == OP_ADD || op == OP_SUB || op == OP_NAND ||
        op[2:0] == OP3_SHIFT) begin
      wr = '{en: 1'b1, idx: ir[R1_MSB:R1_LSB]};
    end else if (op[2:0] == OP3_ORI) begin
      wr = '{en: 1'b1, idx: ORI_REG};
    end
    return wr;
  endfunction

  // Source registers of an instruction: {first operand, second operand}.
  function automatic logic [5:0] dec_read(input logic [7:0] ir);
    logic [3:0] op;
    reg_ref_t   rd1;
    reg_ref_t   rd2;
    op  = ir[OP_MSB:OP_LSB];
    rd1 = '0;
    rd2 = '0;
    case (op)
      OP_ADD, OP_SUB, OP_NAND, OP_STORE: begin
        rd1 = '{en: 1'b1, idx: ir[R1_MSB:R1_LSB]};
        rd2 = '{en: 1'b1, idx: ir[R2_MSB:R2_LSB]};
      end
      OP_LOAD: rd2 = '{en: 1'b1, idx: ir[R2_MSB:R2_LSB]};
      OP_STOP, OP_BZ, OP_BNZ, OP_BPZ, OP_NOP: begin
        rd1 = '0;
        rd2 = '0;
      end
      default: begin
        if (op[2:0] == OP3_SHIFT) begin
          rd1 = '{en: 1'b1, idx: ir[R1_MSB:R1_LSB]};
        end else if (op[2:0] == OP3_ORI) begin
          rd1 = '{en: 1'b1, idx: ORI_REG};
        end
      end
    endcase
    return {rd1, rd2};
  endfunction

  function automatic logic hits(input reg_ref_t rd, input reg_ref_t wr);
    return rd.en && wr.en && (rd.idx == wr.idx);
  endfunction

  reg_ref_t w_rd1;
  reg_ref_t w_rd2;
  reg_ref_t w_wr_e;
  reg_ref_t w_wr_w;

  assign {w_rd1, w_rd2} = dec_read(i_ir_d);
  assign w_wr_e         = dec_write(i_ir_e);
  assign w_wr_w         = dec_write(i_ir_w);

  assign o_hazard = hits(w_rd1, w_wr_e) | hits(w_rd1, w_wr_w) |
                    hits(w_rd2, w_wr_e) | hits(w_rd2, w_wr_w);

  // R2 fields of the older instructions never matter: they only write R1.
  logic w_unused_fields;
  assign w_unused_fields = ^{i_ir_e[R2_MSB:R2_LSB], i_ir_w[R2_MSB:R2_LSB]};

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer for the four-stage (F, D, E, W) processor.
// Generates the PC and D/E/W instruction-register load/clear enables, stalls D
// on read-after-write hazards, squashes wrong-path instructions on a taken
// branch, drains and halts on a retiring stop, and keeps saturating cycle and
// hazard-stall counters.
//
// Ports:
//   clock, resetn     system clock, asynchronous active-low reset
//   ir_d/ir_e/ir_w    instructions currently in D, E and W
//   branch_taken      E-stage branch resolved taken this cycle
//   pc_load           PC advances (or takes the branch target)
//   ir_d_load/flush_d D register capture / load nop (flush wins)
//   ir_e_load/bubble_e E register capture / load nop (bubble wins)
//   ir_w_load         W register captures E
//   halted            pipeline stopped (registered)
//   cycle_count       cycles spent not halted, saturating
//   stall_count       hazard stall cycles, saturating
module pipeline_sequencer
  import processor_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [7:0]         ir_d,
  input  logic [7:0]         ir_e,
  input  logic [7:0]         ir_w,
  input  logic               branch_taken,
  output logic               pc_load,
  output logic               ir_d_load,
  output logic               flush_d,
  output logic               ir_e_load,
  output logic               bubble_e,
  output logic               ir_w_load,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [STALL_W-1:0] stall_count
);

  state_e               r_state;
  state_e               w_state_next;
  logic [CNT_W-1:0]     r_cycle_count;
  logic [STALL_W-1:0]   r_stall_count;

  logic w_hazard;
  logic w_d_is_stop;
  logic w_w_is_stop;
  logic w_stall_inc;
  logic w_pc_load;
  logic w_ir_d_load;
  logic w_flush_d;
  logic w_ir_e_load;
  logic w_bubble_e;
  logic w_ir_w_load;

  hazard_unit u_hazard_unit (
    .i_ir_d   (ir_d),
    .i_ir_e   (ir_e),
    .i_ir_w   (ir_w),
    .o_hazard (w_hazard)
  );

  assign w_d_is_stop = (ir_d[OP_MSB:OP_LSB] == OP_STOP);
  assign w_w_is_stop = (ir_w[OP_MSB:OP_LSB] == OP_STOP);

  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_ir_d_load  = 1'b0;
    w_flush_d    = 1'b0;
    w_ir_e_load  = 1'b0;
    w_bubble_e   = 1'b0;
    w_ir_w_load  = 1'b0;
    w_stall_inc  = 1'b0;

    unique case (r_state)
      RUN: begin
        if (branch_taken) begin
          // Squash the wrong-path instructions in D and E.
          w_pc_load   = 1'b1;
          w_flush_d   = 1'b1;
          w_bubble_e  = 1'b1;
          w_ir_w_load = 1'b1;
        end else if (w_hazard) begin
          // Hold F and D, let the writer move on, insert a bubble into E.
          w_bubble_e  = 1'b1;
          w_ir_w_load = 1'b1;
          w_stall_inc = 1'b1;
        end else if (w_d_is_stop) begin
          w_flush_d    = 1'b1;
          w_ir_e_load  = 1'b1;
          w_ir_w_load  = 1'b1;
          w_state_next = DRAIN;
        end else begin
          w_pc_load   = 1'b1;
          w_ir_d_load = 1'b1;
          w_ir_e_load = 1'b1;
          w_ir_w_load = 1'b1;
        end
      end

      DRAIN: begin
        if (branch_taken) begin
          // An older branch ahead of the stop discards it; resume fetching.
          w_pc_load    = 1'b1;
          w_flush_d    = 1'b1;
          w_bubble_e   = 1'b1;
          w_ir_w_load  = 1'b1;
          w_state_next = RUN;
        end else begin
          w_flush_d   = 1'b1;
          w_ir_e_load = 1'b1;
          w_ir_w_load = 1'b1;
          if (w_w_is_stop) begin
            w_state_next = HALTED;
          end
        end
      end

      HALTED: w_state_next = HALTED;

      default: w_state_next = RUN;
    endcase
  end

  // Enables are held off while reset is asserted.
  assign pc_load   = resetn & w_pc_load;
  assign ir_d_load = resetn & w_ir_d_load;
  assign flush_d   = resetn & w_flush_d;
  assign ir_e_load = resetn & w_ir_e_load;
  assign bubble_e  = resetn & w_bubble_e;
  assign ir_w_load = resetn & w_ir_w_load;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= RUN;
      r_cycle_count <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_next;
      // The cycle that enters HALTED is still counted: r_state is DRAIN then.
      if (r_state != HALTED && r_cycle_count != '1) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      if (w_stall_inc && r_stall_count != '1) begin
        r_stall_count <= r_stall_count + STALL_W'(1);
      end
    end
  end

  assign halted      = (r_state == HALTED);
  assign cycle_count = r_cycle_count;
  assign stall_count = r_stall_count;

endmodule
